// File: rtl/sha3_state_gather_from_48.sv
// Gathers 34 beats of 48 bits into a 1600-bit SHA3 state (25 x 64-bit lanes) plus 16 spare bits.
// Latency: ovalid rises 1 cycle after the beat-33 transfer; at least 35 cycles per state.
// Backpressure: iready drops while a completed state is held; release only on oready, no accept-while-drain.
module sha3_state_gather_from_48 #(
    parameter int unsigned CHECK_PAD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ivalid,
    input  logic [47:0] islice,
    output logic        iready,
    output logic        ovalid,
    input  logic        oready,
    output logic [63:0] olane [25],
    output logic [15:0] ospare,
    output logic        opad_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [1599:0] s_q, s_d;
    logic [15:0]   spare_q, spare_d;
    logic          perr_q, perr_d;
    logic          iready_q, iready_d;
    logic          ovalid_q, ovalid_d;
    logic          xfer;

    assign xfer = ivalid && iready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        spare_d  = spare_q;
        perr_d   = perr_q;
        iready_d = iready_q;
        ovalid_d = ovalid_q;
        unique case (state_q)
            COLLECT: begin
                if (xfer) begin
                    if (cnt_q == 6'd33) begin
                        // Final beat: low 16 bits of lane 24, pad field, side-band bits.
                        s_d[15:0] = islice[47:32];
                        spare_d   = islice[15:0];
                        perr_d    = (CHECK_PAD != 0) && (islice[31:16] != 16'd0);
                        cnt_d     = 6'd0;
                        state_d   = HOLD;
                        iready_d  = 1'b0;
                        ovalid_d  = 1'b1;
                    end else begin
                        for (int k = 0; k < 33; k++) begin
                            if (cnt_q == 6'(k)) begin
                                s_d[1599-48*k -: 48] = islice;
                            end
                        end
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (oready) begin
                    state_d  = COLLECT;
                    iready_d = 1'b1;
                    ovalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = COLLECT;
                iready_d = 1'b1;
                ovalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            cnt_q    <= 6'd0;
            s_q      <= '0;
            spare_q  <= 16'd0;
            perr_q   <= 1'b0;
            iready_q <= 1'b1;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            spare_q  <= spare_d;
            perr_q   <= perr_d;
            iready_q <= iready_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Lane 0 occupies the most significant 64 bits of the gathered state.
    for (genvar i = 0; i < 25; i++) begin : g_lane
        assign olane[i] = s_q[1599-64*i -: 64];
    end

    assign iready   = iready_q;
    assign ovalid   = ovalid_q;
    assign ospare   = spare_q;
    assign opad_err = perr_q;

endmodule

// File: doc/sha3_state_gather_from_48.md
SHA3_STATE_GATHER_FROM_48 -- requirements
Module: sha3_state_gather_from_48

Interface
REQ-001 The block SHALL have one parameter: CHECK_PAD, default 1, enables the padding check on the final beat (0 = opad_err tied low).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ivalid  input  1  islice carries a valid beat.
REQ-005 islice  input  48  packed 48-bit beat of the serialized 1600-bit state.
REQ-006 iready  output  1  block accepts a beat this cycle.
REQ-007 ovalid  output  1  olane/ospare/opad_err hold a complete state.
REQ-008 oready  input  1  consumer takes the completed state.
REQ-009 olane  output  25 x 64  reassembled lanes, olane[0]..olane[24].
REQ-010 ospare  output  16  side-band bits from the final beat.
REQ-011 opad_err  output  1  final beat padding field was nonzero.

Function
REQ-012 A beat SHALL transfer on a rising edge where ivalid and iready are both 1; ivalid with iready low SHALL be ignored and islice SHALL be don't-care when ivalid is 0.
REQ-013 The block SHALL run a two-state FSM: COLLECT (iready=1, ovalid=0) and HOLD (iready=0, ovalid=1); iready and ovalid SHALL be decoded from state registers only, with no combinational path from ivalid or oready.
REQ-014 A 6-bit beat counter SHALL count transfers 0..33 in COLLECT.
REQ-015 With S = {olane[0], olane[1], ..., olane[24]} (1600 bits, lane 0 at MSB), beat k for k = 0..32 SHALL be written to S[1599-48k : 1552-48k].
REQ-016 Beat k = 0..32 mapping SHALL therefore be: every 4 beats cover 3 lanes -- beat 4m = lane 3m[63:16]; beat 4m+1 = {lane 3m[15:0], lane 3m+1[63:32]}; beat 4m+2 = {lane 3m+1[31:0], lane 3m+2[63:48]}; beat 4m+3 = lane 3m+2[47:0].
REQ-017 Beat 33 SHALL be decoded as {olane[24][15:0], pad[15:0], ospare[15:0]} from islice[47:32], islice[31:16], islice[15:0].
REQ-018 On transfer of beat 33, state SHALL go to HOLD and the counter SHALL reset to 0 on the same edge; ovalid SHALL be 1 in the cycle after the beat-33 transfer (latency 1).
REQ-019 opad_err SHALL be registered on the beat-33 transfer as (islice[31:16] != 0) when CHECK_PAD=1, else 0, and SHALL be valid only while ovalid=1.
REQ-020 In HOLD, olane, ospare and opad_err SHALL be stable until the edge where oready=1.
REQ-021 On the HOLD edge with oready=1, the FSM SHALL return to COLLECT; ovalid falls and iready rises in the following cycle; no same-cycle accept-while-drain (minimum 35 cycles per state).
REQ-022 olane/ospare registers SHALL NOT be cleared between blocks; every bit is overwritten by the next 34 beats.
REQ-023 oready while ovalid=0 SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force state=COLLECT, counter=0, ovalid=0, opad_err=0, olane all 0, ospare=0; iready SHALL be 1 from the first edge after rst_n deasserts.
REQ-025 Reset asserted mid-collection or during HOLD SHALL discard the partial or pending state; the next accepted beat is beat 0.

Verification
REQ-026 Lanes lane[i] = 64'h0101010101010101*i, spare 16'hBEEF, pad 0, ivalid held 1 -> ovalid 1 cycle after beat 33, olane[i] exact, ospare=16'hBEEF, opad_err=0.
REQ-027 Same stream with beat-33 islice[31:16]=16'h0001 -> opad_err=1 (CHECK_PAD=1); =0 with CHECK_PAD=0.
REQ-028 Random ivalid gaps (about 50% duty) -> identical olane to REQ-026; counter advances only on transfers.
REQ-029 oready held 0 for 10 cycles in HOLD with ivalid=1 -> iready stays 0, outputs stable; oready=1 -> next cycle iready=1, ovalid=0; second block with inverted data decodes correctly.
REQ-030 rst_n pulsed low after beat 17 -> all outputs 0; fresh 34-beat stream decodes with no carry-over.
REQ-031 Back-to-back blocks with oready tied 1 -> one ovalid pulse per block, spacing exactly 35 cycles.
